uart_tx_arb: RTL

- Shares one UART transmitter between num_ports byte-stream requesters, with message-granular round-robin arbitration.
- Once a port is granted, it keeps the transmitter until it presents a byte with in_last, or until it stalls past a timeout.
- Sits between message sources (hello generator, debug/status streams) and the transmitter's tx_data/tx_req/tx_cts/tx_idle interface.

---
 rtl/uart_tx_arb.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arb
//  Description : Message-granular round-robin arbiter sharing one UART
//                transmitter between NUM_PORTS byte-stream requesters.
//                A granted port owns the transmitter until its last byte
//                is accepted or it stalls past TIMEOUT_CYCLES.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb #(
    parameter int NUM_PORTS      = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int ID_BITS       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                   ser_clk,
    input  logic                   rst_n,
    input  logic [NUM_PORTS-1:0]   in_valid,
    input  logic [8*NUM_PORTS-1:0] in_data,
    input  logic [NUM_PORTS-1:0]   in_last,
    output logic [NUM_PORTS-1:0]   in_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_req,
    input  logic                   tx_cts,
    input  logic                   tx_idle,
    output logic                   grant_valid,
    output logic [ID_BITS-1:0]     grant_id,
    output logic                   err_timeout
);

    localparam int                  CNT_BITS    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_BITS-1:0] c_cnt_max   = CNT_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]          c_idle_byte = 8'hFF;
    localparam logic [ID_BITS-1:0]  c_rr_init   = ID_BITS'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_IDLE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ID_BITS-1:0]  grant_id_q, grant_id_d;
    logic                grant_valid_q, grant_valid_d;
    logic [ID_BITS-1:0]  rr_last_q, rr_last_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    logic                w_sel_valid;
    logic                w_sel_last;
    logic [7:0]          w_sel_data;
    logic                w_pick_found;
    logic [ID_BITS-1:0]  w_pick_id;
    logic [ID_BITS-1:0]  w_cand;

    // Route the currently granted port's stream onto the shared signals.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = 8'h00;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_id_q == ID_BITS'(i)) begin
                w_sel_valid = in_valid[i];
                w_sel_last  = in_last[i];
                w_sel_data  = in_data[8*i +: 8];
            end
        end
    end

    // Round-robin pick: first valid port after the last owner, with wrap.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_id    = '0;
        w_cand       = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_cand = ID_BITS'((int'(rr_last_q) + k) % NUM_PORTS);
            if (!w_pick_found && in_valid[w_cand]) begin
                w_pick_found = 1'b1;
                w_pick_id    = w_cand;
            end
        end
    end

    // Next-state and output decode; outputs idle outside SEND.
    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        rr_last_d     = rr_last_q;
        cnt_d         = cnt_q;
        tx_req        = 1'b0;
        tx_data       = c_idle_byte;
        in_ready      = '0;
        err_timeout   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_pick_found) begin
                    state_d       = S_SEND;
                    grant_id_d    = w_pick_id;
                    grant_valid_d = 1'b1;
                    cnt_d         = '0;
                end
            end
            S_SEND: begin
                tx_req  = w_sel_valid;
                tx_data = w_sel_data;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    in_ready[i] = (grant_id_q == ID_BITS'(i)) && tx_cts;
                end
                if (w_sel_valid && tx_cts) begin
                    cnt_d = '0;
                    if (w_sel_last) begin
                        state_d   = S_WAIT_IDLE;
                        rr_last_d = grant_id_q;
                    end
                end else if (!w_sel_valid) begin
                    // Stalled source: abort once the budget is spent.
                    if (cnt_q == c_cnt_max) begin
                        err_timeout = 1'b1;
                        state_d     = S_WAIT_IDLE;
                        rr_last_d   = grant_id_q;
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
                // Backpressure (valid high, cts low) holds the counter.
            end
            S_WAIT_IDLE: begin
                if (tx_idle) begin
                    state_d       = S_IDLE;
                    grant_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and grant registers with asynchronous reset.
    always_ff @(posedge ser_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            rr_last_q     <= c_rr_init;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            rr_last_q     <= rr_last_d;
            cnt_q         <= cnt_d;
        end
    end

    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;

endmodule
`default_nettype wire
